// File: rtl/fec_ctrl.sv
// fec_ctrl: sequencer that frames one uncoded data block into the RS / CC
// encoder pipeline. It latches the block configuration, streams data bits,
// reserves RS parity slots, and appends the zero tail that flushes the CC state.
// Optional feature macro: FEC_CTRL_PAD_EN. When it is defined, a short block is
// padded with 1-bits up to blk_bits. When it is undefined, a short block pulses
// err_short and proceeds straight to the parity/tail phase.
module fec_ctrl #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned TAIL_BITS   = 6,
  parameter int unsigned RS_PAR_BITS = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_blk_bits,
  input  logic             cfg_rs_en,
  input  logic [1:0]       cfg_cc_rate,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             enc_ready,
  output logic             enc_bit,
  output logic             enc_valid,
  output logic             enc_flush,
  output logic             enc_par,
  output logic             enc_rs_en,
  output logic [1:0]       enc_cc_rate,
  output logic             busy,
  output logic             done,
  output logic             err_short
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DATA  = 3'd2,
`ifdef FEC_CTRL_PAD_EN
    S_PAD   = 3'd3,
`endif
    S_RSPAR = 3'd4,
    S_TAIL  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(RS_PAR_BITS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);

  state_t           state_q, state_d, post_data;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] blk_bits_q, blk_bits_d;
  logic [CNT_W-1:0] data_last;
  logic             rs_en_d;
  logic [1:0]       cc_rate_d;
  logic             enc_bit_d, enc_valid_d, enc_flush_d, enc_par_d;
  logic             busy_d, done_d, err_short_d;

  // Index of the final data bit and the phase that follows the data phase.
  assign data_last = blk_bits_q - CNT_W'(1);
  assign post_data = enc_rs_en ? S_RSPAR : S_TAIL;

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      blk_bits_q  <= '0;
      enc_bit     <= 1'b0;
      enc_valid   <= 1'b0;
      enc_flush   <= 1'b0;
      enc_par     <= 1'b0;
      enc_rs_en   <= 1'b0;
      enc_cc_rate <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_bits_q  <= blk_bits_d;
      enc_bit     <= enc_bit_d;
      enc_valid   <= enc_valid_d;
      enc_flush   <= enc_flush_d;
      enc_par     <= enc_par_d;
      enc_rs_en   <= rs_en_d;
      enc_cc_rate <= cc_rate_d;
      busy        <= busy_d;
      done        <= done_d;
      err_short   <= err_short_d;
    end
  end

  // Next-state, counter and output-next logic; in_ready is the only direct output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_bits_d  = blk_bits_q;
    rs_en_d     = enc_rs_en;
    cc_rate_d   = enc_cc_rate;
    enc_bit_d   = 1'b0;
    enc_valid_d = 1'b0;
    enc_flush_d = 1'b0;
    enc_par_d   = 1'b0;
    done_d      = 1'b0;
    err_short_d = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_bits_d = cfg_blk_bits;
          rs_en_d    = cfg_rs_en;
          cc_rate_d  = cfg_cc_rate;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (blk_bits_q == '0) state_d = post_data;
        else                  state_d = S_DATA;
      end

      S_DATA: begin
        in_ready = enc_ready;
        if (in_valid && enc_ready) begin
          enc_bit_d   = in_bit;
          enc_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == data_last) begin
            // in_last on the final bit carries no extra meaning
            state_d = post_data;
            cnt_d   = '0;
          end else if (in_last) begin
`ifdef FEC_CTRL_PAD_EN
            state_d = S_PAD;
`else
            err_short_d = 1'b1;
            state_d     = post_data;
            cnt_d       = '0;
`endif
          end
        end
      end

`ifdef FEC_CTRL_PAD_EN
      S_PAD: begin
        if (enc_ready) begin
          enc_bit_d   = 1'b1;
          enc_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == data_last) begin
            state_d = post_data;
            cnt_d   = '0;
          end
        end
      end
`endif

      S_RSPAR: begin
        if (enc_ready) begin
          enc_par_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == PAR_LAST) begin
            state_d = S_TAIL;
            cnt_d   = '0;
          end
        end
      end

      S_TAIL: begin
        if (enc_ready) begin
          enc_valid_d = 1'b1;
          enc_flush_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == TAIL_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
